// File: rtl/ralu_pkg.sv
// Shared definitions for the register-ALU datapath: ALU op codes, RgB modes and multiply FSM states.
package ralu_pkg;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_INC   = 4'd2;
    localparam logic [3:0] OP_DEC   = 4'd3;
    localparam logic [3:0] OP_AND   = 4'd4;
    localparam logic [3:0] OP_OR    = 4'd5;
    localparam logic [3:0] OP_XOR   = 4'd6;
    localparam logic [3:0] OP_NOTA  = 4'd7;
    localparam logic [3:0] OP_PASSA = 4'd8;
    localparam logic [3:0] OP_PASSB = 4'd9;

    localparam logic [1:0] B_HOLD = 2'b00;
    localparam logic [1:0] B_SHL  = 2'b01;
    localparam logic [1:0] B_SHR  = 2'b10;
    localparam logic [1:0] B_LOAD = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } mul_state_t;

endpackage

// File: rtl/ralu_alu.sv
// Combinational W-bit ALU; carry-out is bit W of the arithmetic sum and 0 for logic ops.
module ralu_alu
    import ralu_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [3:0]   op,
    input  logic         cin,
    output logic [W-1:0] r,
    output logic         cout
);

    logic [W:0] sum;
    logic       arith;

    always_comb begin
        sum   = '0;
        arith = 1'b0;
        r     = '0;
        cout  = 1'b0;
        case (op)
            OP_ADD: begin
                sum   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
                arith = 1'b1;
            end
            OP_SUB: begin
                sum   = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, cin};
                arith = 1'b1;
            end
            OP_INC: begin
                sum   = {1'b0, a} + {{W{1'b0}}, 1'b1};
                arith = 1'b1;
            end
            // Adding all-ones gives A-1 with carry set exactly when no borrow occurs.
            OP_DEC: begin
                sum   = {1'b0, a} + {1'b0, {W{1'b1}}};
                arith = 1'b1;
            end
            OP_AND:   r = a & b;
            OP_OR:    r = a | b;
            OP_XOR:   r = a ^ b;
            OP_NOTA:  r = ~a;
            OP_PASSA: r = a;
            OP_PASSB: r = b;
            default:  r = '0;
        endcase
        if (arith) begin
            r    = sum[W-1:0];
            cout = sum[W];
        end
    end

endmodule

// File: rtl/ralu_seq.sv
// Register-ALU execution core: register file, RgA/RgB, ALU, accumulator and optional
// shift-and-add multiplier, enabled by defining RALU_MUL_EN.
module ralu_seq
    import ralu_pkg::*;
#(
    parameter  int W  = 4,
    parameter  int N  = 8,
    localparam int AW = $clog2(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [W-1:0]  data_in,
    input  logic          a_sel,
    input  logic [3:0]    v,
    input  logic [AW-1:0] adr_a,
    input  logic [AW-1:0] adr_b,
    input  logic [AW-1:0] adr_w,
    input  logic          wr,
    input  logic [3:0]    op,
    input  logic          cin,
    input  logic          isl,
    input  logic          isr,
    input  logic          mul_start,
    output logic [W-1:0]  rout,
    output logic          cout,
    output logic          osl,
    output logic          osr,
    output logic          flag_z,
    output logic          flag_n,
    output logic          busy,
    output logic          done
);

    logic [W-1:0] rf [N];
    logic [W-1:0] rg_a;
    logic [W-1:0] rg_b;
    logic [W-1:0] acc;
    logic [W-1:0] alu_r;
    logic         ctrl_en;

`ifdef RALU_MUL_EN
    localparam int CW = $clog2(W + 1);

    mul_state_t   state;
    logic [CW-1:0] count;
    logic          mul_carry;
    logic [W:0]    mul_sum;

    assign mul_sum = {mul_carry, acc} + {1'b0, (rg_b[0] ? rg_a : {W{1'b0}})};
    assign ctrl_en = ~busy;
`else
    logic unused_mul_start;

    assign unused_mul_start = mul_start;
    assign busy    = 1'b0;
    assign done    = 1'b0;
    assign ctrl_en = 1'b1;
`endif

    ralu_alu #(.W(W)) u_alu (
        .a    (rg_a),
        .b    (rg_b),
        .op   (op),
        .cin  (cin),
        .r    (alu_r),
        .cout (cout)
    );

    assign rout = (v[3] && ctrl_en) ? alu_r : acc;

    // Reads are combinational, so a same-cycle read of the written address sees the old entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                rf[i] <= '0;
            end
        end else if (wr && ctrl_en) begin
            rf[adr_w] <= alu_r;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rg_a   <= '0;
            rg_b   <= '0;
            acc    <= '0;
            osl    <= 1'b0;
            osr    <= 1'b0;
            flag_z <= 1'b0;
            flag_n <= 1'b0;
`ifdef RALU_MUL_EN
            state     <= S_IDLE;
            count     <= '0;
            mul_carry <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
`endif
        end else begin
            if (ctrl_en) begin
                if (v[0]) begin
                    rg_a <= a_sel ? data_in : rf[adr_a];
                end
                case (v[2:1])
                    B_LOAD:  rg_b <= rf[adr_b];
                    B_SHL:   {osl, rg_b} <= {rg_b, isl};
                    B_SHR:   {rg_b, osr} <= {isr, rg_b};
                    default: ;
                endcase
                if (v[3]) begin
                    acc    <= alu_r;
                    flag_z <= (alu_r == '0);
                    flag_n <= alu_r[W-1];
                end
            end
`ifdef RALU_MUL_EN
            // A start clears ACC, overriding any accumulator load in the same cycle.
            case (state)
                S_IDLE: begin
                    if (mul_start) begin
                        state     <= S_RUN;
                        busy      <= 1'b1;
                        acc       <= '0;
                        mul_carry <= 1'b0;
                        count     <= CW'(W);
                    end
                end
                S_RUN: begin
                    {mul_carry, acc, rg_b} <= {mul_sum, rg_b} >> 1;
                    count <= count - CW'(1);
                    if (count == CW'(1)) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state  <= S_IDLE;
                    busy   <= 1'b0;
                    done   <= 1'b0;
                    flag_z <= (acc == '0);
                    flag_n <= acc[W-1];
                end
                default: state <= S_IDLE;
            endcase
`endif
        end
    end

endmodule

// File: tb/tb_ralu_seq.sv
// Self-checking bench for ralu_seq: directed vector table, randomized model comparison and
// multiply sequences when RALU_MUL_EN is defined.
module tb_ralu_seq;

    localparam int W    = 4;
    localparam int N    = 8;
    localparam int AW   = 3;
    localparam int MASK = (1 << W) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [W-1:0]  data_in;
    logic          a_sel;
    logic [3:0]    v;
    logic [AW-1:0] adr_a, adr_b, adr_w;
    logic          wr;
    logic [3:0]    op;
    logic          cin, isl, isr;
    logic          mul_start;
    logic [W-1:0]  rout;
    logic          cout, osl, osr, flag_z, flag_n, busy, done;

    int checks = 0;
    int errors = 0;

    ralu_seq #(.W(W), .N(N)) dut (
        .clk(clk), .reset(reset), .data_in(data_in), .a_sel(a_sel), .v(v),
        .adr_a(adr_a), .adr_b(adr_b), .adr_w(adr_w), .wr(wr), .op(op), .cin(cin),
        .isl(isl), .isr(isr), .mul_start(mul_start), .rout(rout), .cout(cout),
        .osl(osl), .osr(osr), .flag_z(flag_z), .flag_n(flag_n), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] data_in;
        logic       a_sel;
        logic [3:0] v;
        logic [2:0] adr_a, adr_b, adr_w;
        logic       wr;
        logic [3:0] op;
        logic       cin, isl, isr;
        logic [3:0] exp_rout;
        logic       exp_cout, exp_osl, exp_osr, exp_z, exp_n;
    } vec_t;

    vec_t vecs[22];

    int m_rf[N];
    int m_a, m_b, m_acc, m_osl, m_osr, m_z, m_n;

    function automatic vec_t mk(input int di, input int as, input int vv, input int aa,
                                input int ab, input int aw, input int w, input int o,
                                input int c, input int il, input int ir, input int er,
                                input int ec, input int eol, input int eor, input int ez,
                                input int en);
        vec_t t;
        t.data_in = 4'(di);  t.a_sel = 1'(as);  t.v = 4'(vv);
        t.adr_a = 3'(aa);    t.adr_b = 3'(ab);  t.adr_w = 3'(aw);
        t.wr = 1'(w);        t.op = 4'(o);      t.cin = 1'(c);
        t.isl = 1'(il);      t.isr = 1'(ir);
        t.exp_rout = 4'(er); t.exp_cout = 1'(ec);
        t.exp_osl = 1'(eol); t.exp_osr = 1'(eor);
        t.exp_z = 1'(ez);    t.exp_n = 1'(en);
        return t;
    endfunction

    // Returns {cout, R} as an integer computed straight from the op definitions.
    function automatic int alu_model(input int o, input int a, input int b, input int c);
        case (o)
            0:       return a + b + c;
            1:       return a + ((~b) & MASK) + c;
            2:       return a + 1;
            3:       return (a == 0) ? MASK : ((a - 1) | (1 << W));
            4:       return a & b;
            5:       return a | b;
            6:       return a ^ b;
            7:       return (~a) & MASK;
            8:       return a;
            9:       return b;
            default: return 0;
        endcase
    endfunction

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input vec_t t);
        data_in = t.data_in; a_sel = t.a_sel; v = t.v;
        adr_a = t.adr_a; adr_b = t.adr_b; adr_w = t.adr_w;
        wr = t.wr; op = t.op; cin = t.cin; isl = t.isl; isr = t.isr;
    endtask

    task automatic clear_inputs();
        data_in = '0; a_sel = 0; v = '0; adr_a = '0; adr_b = '0; adr_w = '0;
        wr = 0; op = 4'd8; cin = 0; isl = 0; isr = 0; mul_start = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1;
        tick();
        reset = 0;
    endtask

`ifdef RALU_MUL_EN
    task automatic load_operands(input int a, input int b);
        clear_inputs();
        data_in = 4'(b); a_sel = 1; v = 4'b0001;
        tick();
        data_in = 4'(a); wr = 1; adr_w = 3'd1;
        tick();
        wr = 0; v = 4'b0110; adr_b = 3'd1;
        tick();
        v = 4'b0000;
    endtask

    // Starts a multiply and returns the number of edges from the start edge until done is seen.
    task automatic run_multiply(input bit junk, output int cycles);
        mul_start = 1;
        v = 4'b0000;
        tick();
        check_output("mul_busy_rise", int'(busy), 1);
        if (junk) begin
            v = 4'b1111; wr = 1; adr_w = 3'd0; a_sel = 1; data_in = 4'd3; op = 4'd8;
        end else begin
            mul_start = 0;
        end
        cycles = 1;
        while (!done && cycles < 3 * W) begin
            tick();
            if (!done) cycles++;
        end
        clear_inputs();
        tick();
        check_output("mul_busy_fall", int'(busy), 0);
        check_output("mul_done_fall", int'(done), 0);
    endtask
`endif

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int t, r, na, nb, exp_r, exp_c, cyc, prod;
        bit seen_done;

        vecs[0]  = mk(8, 1, 4'b0001, 0, 0, 0, 0, 8, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        vecs[1]  = mk(9, 1, 4'b0001, 0, 0, 2, 1, 8, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        vecs[2]  = mk(0, 0, 4'b0110, 0, 2, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        vecs[3]  = mk(0, 0, 4'b1000, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0);
        vecs[4]  = mk(0, 0, 4'b0000, 0, 0, 0, 0, 4, 0, 0, 0,  1, 0, 0, 0, 0, 0);
        vecs[5]  = mk(11, 1, 4'b0001, 0, 0, 0, 0, 1, 1, 0, 0, 1, 1, 0, 0, 0, 0);
        vecs[6]  = mk(0, 0, 4'b0000, 0, 0, 4, 1, 8, 0, 0, 0,  1, 0, 0, 0, 0, 0);
        vecs[7]  = mk(0, 0, 4'b0110, 0, 4, 0, 0, 9, 0, 0, 0,  1, 0, 0, 0, 0, 0);
        vecs[8]  = mk(0, 0, 4'b0010, 0, 0, 0, 0, 9, 0, 0, 0,  1, 0, 1, 0, 0, 0);
        vecs[9]  = mk(0, 0, 4'b0100, 0, 0, 0, 0, 9, 0, 0, 1,  1, 0, 1, 0, 0, 0);
        vecs[10] = mk(0, 0, 4'b1000, 0, 0, 0, 0, 9, 0, 0, 0, 11, 0, 1, 0, 0, 1);
        vecs[11] = mk(0, 0, 4'b0100, 0, 0, 0, 0, 2, 0, 0, 0, 11, 0, 1, 1, 0, 1);
        vecs[12] = mk(5, 1, 4'b0001, 0, 0, 0, 0, 3, 0, 0, 0, 11, 1, 1, 1, 0, 1);
        vecs[13] = mk(0, 0, 4'b0001, 3, 0, 3, 1, 8, 0, 0, 0, 11, 0, 1, 1, 0, 1);
        vecs[14] = mk(0, 0, 4'b1000, 0, 0, 0, 0, 8, 0, 0, 0,  0, 0, 1, 1, 1, 0);
        vecs[15] = mk(0, 0, 4'b0001, 3, 0, 0, 0, 3, 0, 0, 0,  0, 0, 1, 1, 1, 0);
        vecs[16] = mk(0, 0, 4'b1000, 0, 0, 0, 0, 5, 0, 0, 0,  5, 0, 1, 1, 0, 0);
        vecs[17] = mk(0, 0, 4'b1000, 0, 0, 0, 0, 7, 0, 0, 0, 10, 0, 1, 1, 0, 1);
        vecs[18] = mk(0, 0, 4'b1000, 0, 0, 0, 0, 12, 0, 0, 0, 0, 0, 1, 1, 1, 0);
        vecs[19] = mk(0, 0, 4'b1000, 0, 0, 0, 0, 0, 1, 0, 0, 11, 0, 1, 1, 0, 1);
        vecs[20] = mk(15, 1, 4'b0001, 0, 0, 0, 0, 2, 0, 0, 0, 11, 0, 1, 1, 0, 1);
        vecs[21] = mk(0, 0, 4'b1000, 0, 0, 0, 0, 2, 0, 0, 0,  0, 1, 1, 1, 1, 0);

        // Dirty the register file and accumulator, then reset.
        do_reset();
        data_in = 4'hF; a_sel = 1; v = 4'b0001;
        tick();
        v = 4'b0000; wr = 1; adr_w = 3'd7;
        tick();
        wr = 0; v = 4'b0001; a_sel = 0; adr_a = 3'd7;
        tick();
        v = 4'b1000; op = 4'd8;
        #1;
        check_output("pre_reset_rf7", int'(rout), 15);
        tick();
        do_reset();
        check_output("reset_rout", int'(rout), 0);
        check_output("reset_flag_z", int'(flag_z), 0);
        check_output("reset_flag_n", int'(flag_n), 0);
        check_output("reset_busy", int'(busy), 0);
        check_output("reset_done", int'(done), 0);
        check_output("reset_osl", int'(osl), 0);
        check_output("reset_osr", int'(osr), 0);
        for (int i = 0; i < N; i++) begin
            v = 4'b0001; a_sel = 0; adr_a = 3'(i);
            tick();
            v = 4'b1000; op = 4'd8;
            #1;
            check_output($sformatf("reset_rf%0d", i), int'(rout), 0);
        end

        do_reset();
        for (int i = 0; i < 22; i++) begin
            apply_stimulus(vecs[i]);
            @(negedge clk);
            check_output($sformatf("vec%0d_rout", i), int'(rout), int'(vecs[i].exp_rout));
            check_output($sformatf("vec%0d_cout", i), int'(cout), int'(vecs[i].exp_cout));
            tick();
            check_output($sformatf("vec%0d_osl", i), int'(osl), int'(vecs[i].exp_osl));
            check_output($sformatf("vec%0d_osr", i), int'(osr), int'(vecs[i].exp_osr));
            check_output($sformatf("vec%0d_z", i), int'(flag_z), int'(vecs[i].exp_z));
            check_output($sformatf("vec%0d_n", i), int'(flag_n), int'(vecs[i].exp_n));
        end

        // Randomized operation against the reference model, with occasional resets.
        do_reset();
        for (int i = 0; i < N; i++) m_rf[i] = 0;
        m_a = 0; m_b = 0; m_acc = 0; m_osl = 0; m_osr = 0; m_z = 0; m_n = 0;
        for (int it = 0; it < 400; it++) begin
            data_in = 4'($urandom); a_sel = 1'($urandom); v = 4'($urandom);
            adr_a = 3'($urandom); adr_b = 3'($urandom); adr_w = 3'($urandom);
            wr = 1'($urandom); op = 4'($urandom_range(0, 12)); cin = 1'($urandom);
            isl = 1'($urandom); isr = 1'($urandom);
            reset = ($urandom_range(0, 39) == 0);
`ifdef RALU_MUL_EN
            mul_start = 0;
`else
            mul_start = 1'($urandom);
`endif
            t = alu_model(int'(op), m_a, m_b, int'(cin));
            r = t & MASK;
            exp_c = (t >> W) & 1;
            exp_r = v[3] ? r : m_acc;
            @(negedge clk);
            check_output("rand_rout", int'(rout), exp_r);
            check_output("rand_cout", int'(cout), exp_c);
            if (reset) begin
                for (int i = 0; i < N; i++) m_rf[i] = 0;
                m_a = 0; m_b = 0; m_acc = 0; m_osl = 0; m_osr = 0; m_z = 0; m_n = 0;
            end else begin
                na = m_a;
                nb = m_b;
                if (v[0]) na = a_sel ? int'(data_in) : m_rf[adr_a];
                case (v[2:1])
                    2'b11: nb = m_rf[adr_b];
                    2'b01: begin
                        m_osl = (m_b >> (W - 1)) & 1;
                        nb = ((m_b << 1) | int'(isl)) & MASK;
                    end
                    2'b10: begin
                        m_osr = m_b & 1;
                        nb = (m_b >> 1) | (int'(isr) << (W - 1));
                    end
                    default: ;
                endcase
                if (v[3]) begin
                    m_acc = r;
                    m_z = (r == 0);
                    m_n = (r >> (W - 1)) & 1;
                end
                if (wr) m_rf[adr_w] = r;
                m_a = na;
                m_b = nb;
            end
            tick();
            check_output("rand_osl", int'(osl), m_osl);
            check_output("rand_osr", int'(osr), m_osr);
            check_output("rand_flag_z", int'(flag_z), m_z);
            check_output("rand_flag_n", int'(flag_n), m_n);
            check_output("rand_busy", int'(busy), 0);
        end
        reset = 0;

`ifdef RALU_MUL_EN
        // 13 x 11 = 143 with stray controls and a second start held during the run.
        do_reset();
        load_operands(13, 11);
        run_multiply(1'b1, cyc);
        check_output("mul_done_latency", cyc, W);
        check_output("mul_acc_hi", int'(rout), 8);
        check_output("mul_flag_z", int'(flag_z), 0);
        check_output("mul_flag_n", int'(flag_n), 1);
        v = 4'b1000; op = 4'd9;
        #1;
        check_output("mul_rgb_lo", int'(rout), 15);
        op = 4'd8;
        #1;
        check_output("mul_rga_kept", int'(rout), 13);
        v = 4'b0000;
        // Back-to-back start in the cycle done dropped: 13 x 15 = 195.
        run_multiply(1'b0, cyc);
        check_output("mul2_done_latency", cyc, W);
        check_output("mul2_acc_hi", int'(rout), 12);
        v = 4'b1000; op = 4'd9;
        #1;
        check_output("mul2_rgb_lo", int'(rout), 3);
        v = 4'b0001; a_sel = 0; adr_a = 3'd0;
        tick();
        v = 4'b1000; op = 4'd8;
        #1;
        check_output("mul_wr_blocked", int'(rout), 0);
        v = 4'b0000;

        // Reset during the second run cycle aborts the multiply.
        load_operands(7, 9);
        mul_start = 1;
        tick();
        mul_start = 0;
        tick();
        reset = 1;
        tick();
        reset = 0;
        check_output("abort_busy", int'(busy), 0);
        check_output("abort_done", int'(done), 0);
        check_output("abort_acc", int'(rout), 0);
        seen_done = 0;
        for (int i = 0; i < W + 3; i++) begin
            tick();
            if (done) seen_done = 1;
        end
        check_output("abort_no_done", int'(seen_done), 0);
        check_output("abort_idle", int'(busy), 0);

        for (int it = 0; it < 20; it++) begin
            int a, b;
            a = $urandom_range(0, MASK);
            b = $urandom_range(0, MASK);
            load_operands(a, b);
            run_multiply(1'b0, cyc);
            prod = int'(rout) << W;
            v = 4'b1000; op = 4'd9;
            #1;
            prod = prod | int'(rout);
            v = 4'b0000;
            check_output("rand_mul_latency", cyc, W);
            check_output("rand_mul_product", prod, a * b);
        end
`else
        // Without the multiplier, mul_start has no effect and controls are never blocked.
        do_reset();
        mul_start = 1; v = 4'b0001; a_sel = 1; data_in = 4'd6;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_output("nomul_busy", int'(busy), 0);
            check_output("nomul_done", int'(done), 0);
        end
        v = 4'b1000; op = 4'd8;
        #1;
        check_output("nomul_v_active", int'(rout), 6);
        tick();
        v = 4'b0000;
        #1;
        check_output("nomul_acc", int'(rout), 6);
        clear_inputs();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
